// File: rtl/ysyx_22041071_ex_stage.sv
// ysyx_22041071_ex_stage: RV64IM execute stage with single-cycle ALU, branch resolve,
// iterative 64-step mul/div and a valid/ready output register towards MEM.
module ysyx_22041071_ex_stage #(
  parameter int XLEN = 64,
  parameter int MD_STEPS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid4,
  output logic            ready4,
  input  logic [XLEN-1:0] PC4,
  input  logic [31:0]     Ins3,
  input  logic            Brch2,
  input  logic [11:0]     BImm2,
  input  logic [4:0]      ALU_ctrl2,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] rt_data1,
  input  logic [4:0]      rdest1,
  input  logic            reg_w_en2,
  input  logic            MEM_W_en2,
  input  logic            WB_sel2,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdest1_,
  output logic            reg_w_en3_,
  output logic            Brch_taken,
  output logic [XLEN-1:0] BPC,
  output logic            valid5,
  input  logic            ready5,
  output logic [XLEN-1:0] PC5,
  output logic [31:0]     Ins4,
  output logic [XLEN-1:0] ALU_out,
  output logic [XLEN-1:0] rt_data2,
  output logic [4:0]      rdest2,
  output logic            reg_w_en4,
  output logic            MEM_W_en3,
  output logic            WB_sel3
);
  localparam int CW = $clog2(MD_STEPS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] alu, aa, bb, ua, ub, hi, lo, dv, ra, md, md_nxt, q, r;
  logic [2*XLEN-1:0] p;
  logic [XLEN:0] s, t, d;
  logic [4:0] mc;
  logic [2:0] f3;
  logic sa, sb, dz, fin, is_md, is_mul, mm, sgn, divw, base, ge, xfer, ld, bub;
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
  always_comb begin
    alu = src_a + src_b;
    case (ALU_ctrl2)
      5'd1:  alu = src_a - src_b;
      5'd2:  alu = src_a << src_b[5:0];
      5'd3:  alu = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      5'd4:  alu = {{(XLEN-1){1'b0}}, src_a < src_b};
      5'd5:  alu = src_a ^ src_b;
      5'd6:  alu = src_a >> src_b[5:0];
      5'd7:  alu = $signed(src_a) >>> src_b[5:0];
      5'd8:  alu = src_a | src_b;
      5'd9:  alu = src_a & src_b;
      5'd10: alu = sx(src_a[31:0] + src_b[31:0]);
      5'd11: alu = sx(src_a[31:0] - src_b[31:0]);
      5'd12: alu = sx(src_a[31:0] << src_b[4:0]);
      5'd13: alu = sx(src_a[31:0] >> src_b[4:0]);
      5'd14: alu = sx($signed(src_a[31:0]) >>> src_b[4:0]);
      default: alu = src_a + src_b;
    endcase
  end
  assign f3 = Ins3[14:12];
  assign base = f3[2:1] == 2'b00 ? src_a == src_b :
                f3[2:1] == 2'b10 ? $signed(src_a) < $signed(src_b) : src_a < src_b;
  assign ready4 = ready5 & (state == IDLE);
  assign xfer = valid4 & ready4;
  assign Brch_taken = xfer & Brch2 & (f3[2:1] != 2'b01) & (base ^ f3[0]);
  assign BPC = PC4 + {{(XLEN-13){BImm2[11]}}, BImm2, 1'b0};
  assign rdest1_ = rdest1;
  assign reg_w_en3_ = reg_w_en2 & valid4;
  assign result = state == DONE ? md : alu;
  assign is_md = ALU_ctrl2 >= 5'd16 && ALU_ctrl2 <= 5'd24;
  assign is_mul = ALU_ctrl2 inside {5'd16, 5'd17, 5'd22};
  assign sgn = ALU_ctrl2 inside {5'd17, 5'd18, 5'd20, 5'd23, 5'd24};
  assign divw = ALU_ctrl2 inside {5'd23, 5'd24};
  assign aa = divw ? sx(src_a[31:0]) : src_a;
  assign bb = divw ? sx(src_b[31:0]) : src_b;
  assign ua = sgn & aa[XLEN-1] ? -aa : aa;
  assign ub = sgn & bb[XLEN-1] ? -bb : bb;
  assign mm = mc inside {5'd16, 5'd17, 5'd22};
  // one shift-add (mul) or restoring-subtract (div) step on {hi,lo}
  assign s = lo[0] ? {1'b0, hi} + {1'b0, dv} : {1'b0, hi};
  assign t = {hi, lo[XLEN-1]};
  assign d = t - {1'b0, dv};
  assign ge = t >= {1'b0, dv};
  assign p = sa ^ sb ? -{hi, lo} : {hi, lo};
  assign q = dz ? '1 : sa ^ sb ? -lo : lo;
  assign r = dz ? ra : sa ? -hi : hi;
  assign md_nxt = mc == 5'd16 ? lo :
                  mc == 5'd17 ? p[2*XLEN-1:XLEN] :
                  mc == 5'd22 ? sx(lo[31:0]) :
                  mc == 5'd23 ? sx(q[31:0]) :
                  mc == 5'd24 ? sx(r[31:0]) :
                  mc inside {5'd18, 5'd19} ? q : r;
  assign ld = ready5 & (state == IDLE | (state == DONE & fin));
  assign bub = state == IDLE & is_md;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      fin <= 1'b0;
      valid5 <= 1'b0;
      PC5 <= '0;
      Ins4 <= '0;
      ALU_out <= '0;
      rt_data2 <= '0;
      rdest2 <= '0;
      reg_w_en4 <= 1'b0;
      MEM_W_en3 <= 1'b0;
      WB_sel3 <= 1'b0;
    end else begin
      if (ld) begin
        valid5 <= state == DONE | valid4;
        PC5 <= PC4;
        Ins4 <= bub ? 32'd0 : Ins3;
        ALU_out <= result;
        rt_data2 <= rt_data1;
        rdest2 <= rdest1;
        reg_w_en4 <= reg_w_en2 & ~bub;
        MEM_W_en3 <= MEM_W_en2 & ~bub;
        WB_sel3 <= WB_sel2 & ~bub;
      end else if (ready5) valid5 <= 1'b0;
      if (state == IDLE && xfer && is_md) begin
        state <= BUSY;
        cnt <= '0;
        mc <= ALU_ctrl2;
        sa <= sgn & aa[XLEN-1];
        sb <= sgn & bb[XLEN-1];
        dz <= bb == '0;
        ra <= aa;
        hi <= '0;
        lo <= is_mul ? ub : ua;
        dv <= is_mul ? ua : ub;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        state <= cnt == CW'(MD_STEPS - 1) ? DONE : BUSY;
        hi <= mm ? s[XLEN:1] : ge ? d[XLEN-1:0] : t[XLEN-1:0];
        lo <= mm ? {s[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], ge};
      end else if (state == DONE) begin
        if (!fin) begin
          md <= md_nxt;
          fin <= 1'b1;
        end else if (ready5) begin
          fin <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
